// File: rtl/serial_bit_feeder_if.sv
// Bus bundle for serial_bit_feeder: load request side plus the serial bit stream
// that drives a downstream enabled flip-flop (sout -> D, sout_valid -> E).
interface serial_bit_feeder_if #(
    parameter int WIDTH = 8
);
    // Handshake: a word is accepted at a rising edge where start=1 and ready=1;
    // start while ready=0 is dropped (no queuing) and load_data is not sampled.
    logic             start;
    logic [WIDTH-1:0] load_data;
    logic             abort;
    logic             ready;
    logic             busy;
    logic             sout;
    logic             sout_valid;
    logic             done;

    modport master (
        output start, load_data, abort,
        input  ready, busy, sout, sout_valid, done
    );

    modport slave (
        input  start, load_data, abort,
        output ready, busy, sout, sout_valid, done
    );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-in/serial-out feeder: emits a WIDTH-bit word one bit per clock with a
// qualifying valid. Define PARITY_EN to append an even-parity bit after the data.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    serial_bit_feeder_if.slave   bus,
    output logic [1:0]           state_dbg_o
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DONE   = 2'd3
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef PARITY_EN
    logic             par_q, par_d;
`endif
    logic             sout_d;

    logic             ready_q, busy_q, sout_q, valid_q, done_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef PARITY_EN
        par_d   = par_q;
`endif
        sout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SHIFT;
                    shift_d = bus.load_data;
                    cnt_d   = '0;
`ifdef PARITY_EN
                    par_d   = ^bus.load_data;
`endif
                end
            end
            ST_SHIFT: begin
                // Abort outranks the end-of-word transition.
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    shift_d = '0;
                    cnt_d   = '0;
                end else begin
                    shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, shift_q[WIDTH-1:1]};
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
`ifdef PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef PARITY_EN
            ST_PARITY: begin
                state_d = bus.abort ? ST_IDLE : ST_DONE;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next-state values.
        case (state_d)
            ST_SHIFT:  sout_d = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
`ifdef PARITY_EN
            ST_PARITY: sout_d = par_d;
`endif
            default:   sout_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
`ifdef PARITY_EN
            par_q   <= par_d;
            busy_q  <= (state_d == ST_SHIFT) || (state_d == ST_PARITY);
            valid_q <= (state_d == ST_SHIFT) || (state_d == ST_PARITY);
`else
            busy_q  <= (state_d == ST_SHIFT);
            valid_q <= (state_d == ST_SHIFT);
`endif
            ready_q <= (state_d == ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            sout_q  <= sout_d;
        end
    end

    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = valid_q;
    assign bus.done       = done_q;
    assign state_dbg_o    = state_q;
endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: an MSB-first and an LSB-first instance, expected
// serial bits queued per instance and compared whenever sout_valid is high.
module tb_serial_bit_feeder;
    localparam int W = 8;
`ifdef PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_bit_feeder_if #(.WIDTH(W)) bus_a ();
    serial_bit_feeder_if #(.WIDTH(W)) bus_b ();
    logic [1:0] dbg_a, dbg_b;

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(bus_a), .state_dbg_o(dbg_a));
    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(bus_b), .state_dbg_o(dbg_b));

    int n_checks = 0;
    int n_fail   = 0;
    logic [0:0] exp_a_q[$];
    logic [0:0] exp_b_q[$];
    logic ff_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Downstream enabled flip-flop fed by the LSB-first instance.
    always @(posedge clk or posedge rst) begin
        if (rst) ff_q <= 1'b0;
        else if (bus_b.sout_valid) ff_q <= bus_b.sout;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.sout_valid === 1'b1) begin
                n_checks++;
                assert (exp_a_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL a_extra_bit: observed=valid expected=no bit pending");
                end
                if (exp_a_q.size() > 0) check("a_sout", bus_a.sout, exp_a_q.pop_front());
            end else begin
                check("a_sout_zero", bus_a.sout, 0);
            end
            if (bus_b.sout_valid === 1'b1) begin
                n_checks++;
                assert (exp_b_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL b_extra_bit: observed=valid expected=no bit pending");
                end
                if (exp_b_q.size() > 0) check("b_sout", bus_b.sout, exp_b_q.pop_front());
            end else begin
                check("b_sout_zero", bus_b.sout, 0);
            end
        end
    end

    task automatic push_bits(input bit to_b, input logic [W-1:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            if (to_b) exp_b_q.push_back(d[i]);
            else      exp_a_q.push_back(d[W-1-i]);
        end
    endtask

    task automatic push_word(input bit to_b, input logic [W-1:0] d);
        push_bits(to_b, d, W);
`ifdef PARITY_EN
        if (to_b) exp_b_q.push_back(^d);
        else      exp_a_q.push_back(^d);
`endif
    endtask

    // Full word on instance A: optional Abort alongside Start, a stray Start mid-word.
    task automatic run_word_a(input logic [W-1:0] d, input string tag, input bit ab);
        push_word(1'b0, d);
        bus_a.load_data = d;
        bus_a.start     = 1'b1;
        bus_a.abort     = ab;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        for (int c = 1; c <= W + PAR; c++) begin
            check({tag, "_valid"}, bus_a.sout_valid, 1);
            check({tag, "_busy"},  bus_a.busy, 1);
            check({tag, "_ready"}, bus_a.ready, 0);
            check({tag, "_done"},  bus_a.done, 0);
            if (c == 3) begin
                bus_a.start     = 1'b1;
                bus_a.load_data = ~d;
            end else begin
                bus_a.start = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, "_done_pulse"}, bus_a.done, 1);
        check({tag, "_done_valid"}, bus_a.sout_valid, 0);
        check({tag, "_done_ready"}, bus_a.ready, 0);
        check({tag, "_done_state"}, dbg_a, 3);
        @(negedge clk);
        check({tag, "_end_ready"}, bus_a.ready, 1);
        check({tag, "_end_done"},  bus_a.done, 0);
        check({tag, "_end_state"}, dbg_a, 0);
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.load_data = '0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.load_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", bus_a.ready, 1);
        check("rst_busy",  bus_a.busy, 0);
        check("rst_sout",  bus_a.sout, 0);
        check("rst_valid", bus_a.sout_valid, 0);
        check("rst_done",  bus_a.done, 0);
        check("rst_state", dbg_a, 0);
        check("rst_b_ready", bus_b.ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Word A5, MSB first, stray Start mid-word is dropped
        run_word_a(8'hA5, "t1", 1'b0);
        @(negedge clk);
        check("t1_no_queue_valid", bus_a.sout_valid, 0);
        check("t1_no_queue_ready", bus_a.ready, 1);

        // Word 01 LSB first into the downstream flip-flop
        push_word(1'b1, 8'h01);
        bus_b.load_data = 8'h01;
        bus_b.start     = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        for (int c = 1; c <= W + PAR; c++) begin
            check("t2_valid", bus_b.sout_valid, 1);
            if (c == 2) check("t2_ff_first", ff_q, 1);
            @(negedge clk);
        end
        check("t2_done", bus_b.done, 1);
`ifdef PARITY_EN
        check("t2_ff_hold", ff_q, 1);
`else
        check("t2_ff_hold", ff_q, 0);
`endif
        @(negedge clk);
`ifdef PARITY_EN
        check("t2_ff_hold2", ff_q, 1);
`else
        check("t2_ff_hold2", ff_q, 0);
`endif
        check("t2_ready", bus_b.ready, 1);

        // Start held high: FF then 00 back to back
        push_word(1'b0, 8'hFF);
        push_word(1'b0, 8'h00);
        bus_a.load_data = 8'hFF;
        bus_a.start     = 1'b1;
        @(negedge clk);
        bus_a.load_data = 8'h00;
        for (int c = 1; c <= W + PAR; c++) begin
            check("t3_w1_valid", bus_a.sout_valid, 1);
            @(negedge clk);
        end
        check("t3_gap1_valid", bus_a.sout_valid, 0);
        check("t3_gap1_done", bus_a.done, 1);
        @(negedge clk);
        check("t3_gap2_valid", bus_a.sout_valid, 0);
        check("t3_gap2_ready", bus_a.ready, 1);
        @(negedge clk);
        bus_a.start = 1'b0;
        for (int c = 1; c <= W + PAR; c++) begin
            check("t3_w2_valid", bus_a.sout_valid, 1);
            @(negedge clk);
        end
        check("t3_w2_done", bus_a.done, 1);
        @(negedge clk);
        check("t3_w2_ready", bus_a.ready, 1);

        // Word 07 (carries a parity bit of 1 when parity is built in)
        run_word_a(8'h07, "t4", 1'b0);

        // Abort at the cycle-4 edge
        push_bits(1'b0, 8'h3C, 4);
        bus_a.load_data = 8'h3C;
        bus_a.start     = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("t5_valid", bus_a.sout_valid, 1);
            if (c == 4) bus_a.abort = 1'b1;
            @(negedge clk);
        end
        bus_a.abort = 1'b0;
        check("t5_abort_valid", bus_a.sout_valid, 0);
        check("t5_abort_ready", bus_a.ready, 1);
        check("t5_abort_busy",  bus_a.busy, 0);
        for (int c = 0; c < 10; c++) begin
            check("t5_no_done", bus_a.done, 0);
            @(negedge clk);
        end
        run_word_a(8'h96, "t5_next", 1'b0);

        // Abort together with Start in IDLE: Start wins
        run_word_a(8'h5A, "t5_start_wins", 1'b1);

        // Random words
        for (int i = 0; i < 3; i++) begin
            run_word_a(W'($urandom_range(0, 255)), "rand", 1'b0);
        end

        // Asynchronous reset in mid-cycle 5
        push_bits(1'b0, 8'hC3, 5);
        bus_a.load_data = 8'hC3;
        bus_a.start     = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("t6_valid", bus_a.sout_valid, 1);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        check("t6_busy",  bus_a.busy, 0);
        check("t6_valid_rst", bus_a.sout_valid, 0);
        check("t6_sout",  bus_a.sout, 0);
        check("t6_ready", bus_a.ready, 1);
        check("t6_state", dbg_a, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("t6_after_ready", bus_a.ready, 1);
        check("t6_after_valid", bus_a.sout_valid, 0);
        run_word_a(8'h3C, "t6_next", 1'b0);

        repeat (2) @(negedge clk);
        check("a_queue_empty", exp_a_q.size(), 0);
        check("b_queue_empty", exp_b_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
